arcade_input_mapper: RTL and testbench
======================================

// Module: arcade_input_mapper
// PURPOSE
//  Multi-player keyboard/joystick input front end for arcade cores. Decodes ps2_key toggle events into held key states.
//  Merges them with per-player joystick words and drives active-high direction/button/start levels to the game core.
//  Shapes coin requests into timed, queued coin pulses for the game's coin inputs; sits between hps_io and the game core.
// PARAMETERS
//  NUM_PLAYERS        2          players, 1..4
//  NUM_BUTTONS        2          fire buttons per player, 1..6
//  COIN_PULSE_CYCLES  1800000    coin high time in clk_sys cycles (100 ms @ 18 MHz), >=1
//  COIN_GAP_CYCLES    1800000    minimum low time between queued coins, >=1
//  AUTOFIRE_PERIOD    270000     half-period of autofire toggle (only with AUTOFIRE_EN), >=1
// PORTS
//  clk_sys      in   1                        system clock
//  reset        in   1                        asynchronous, active-high
//  ps2_key      in   11                       [10] event toggle, [9] pressed, [8] extended, [7:0] scancode
//  joy_in       in   16*NUM_PLAYERS           player p word at [16p+15:16p]
//  dir_out      out  4*NUM_PLAYERS            per player {up,down,left,right}
//  btn_out      out  NUM_BUTTONS*NUM_PLAYERS  per player, button k at [NUM_BUTTONS*p+k]
//  start_out    out  NUM_PLAYERS              start levels
//  coin_out     out  NUM_PLAYERS              shaped coin pulses
//  coin_busy    out  1                        OR of all coin channels not IDLE or with pending>0
//  autofire_en  in   NUM_BUTTONS*NUM_PLAYERS  per-button autofire enable (only with AUTOFIRE_EN)
// BEHAVIOUR
//  Reset: all key states 0, all outputs 0, coin FSMs IDLE, pending 0, toggle tracker unprimed.
//  Key events: first clk after reset samples ps2_key[10] into tracker (primed), no event.
//   Thereafter a change of [10] vs tracker is one event; key state <= ps2_key[9]. Latency 1 clk to key state.
//  Key table: P0 arrows 75/72/6B/74 (match regardless of [8]), buttons 29 space, 14 ctrl (either [8]),
//   11 alt, 12, 1A, 22; start 16 '1'; coin 2E '5'.
//  Key table: P1 R 2D, F 2B, D 23, G 34; buttons 1C, 1B, 15, 1D, 24, 2C; start 1E '2'; coin 36 '6'.
//  Players 2,3: joystick only. Unlisted codes and buttons >= NUM_BUTTONS ignored.
//  Joystick word: [0] right, [1] left, [2] down, [3] up, [4+k] button k,
//   [4+NUM_BUTTONS] start, [5+NUM_BUTTONS] coin.
//  Levels: dir/btn/start = registered (key_state | joy bit); 1 clk after key state / joy change.
//  Coin raw = key | joy coin bit; rising edge (registered previous) = one request.
//  Coin FSM per player: IDLE -> PULSE on request or pending>0; coin_out=1 for exactly COIN_PULSE_CYCLES clks.
//   PULSE -> GAP, coin_out=0 for COIN_GAP_CYCLES. GAP -> PULSE if pending>0 (decrement), else IDLE.
//  pending: 2-bit saturating at 3; request while PULSE/GAP increments; extra requests at 3 dropped.
//  Request in IDLE starts PULSE next clk without touching pending; simultaneous request+GAP exit: both count.
//  Held coin never re-triggers. Reset mid-pulse: coin_out drops asynchronously, queue cleared.
//  Counters sized $clog2(max(COIN_PULSE_CYCLES,COIN_GAP_CYCLES)+1); no wrap beyond terminal count.
// CONFIGURATION
//  `define AUTOFIRE_EN: autofire_en port exists. Per button with enable=1 while held: output 1 immediately,
//   then toggles every AUTOFIRE_PERIOD clks; release -> 0 next clk and phase counter restarts.
//   One free-running phase counter per player, reset on that player's first held autofire button.
//  Without AUTOFIRE_EN: port absent, no counters; btn_out is the plain merged level.
// STRUCTURE
//  Package arcade_input_pkg: JOY_RIGHT/LEFT/DOWN/UP/BTN0 bit indices, scancode localparams per player,
//   typedef enum logic [1:0] {COIN_IDLE,COIN_PULSE,COIN_GAP} coin_state_t.
//  Sub-module arcade_coin_pulser (one coin FSM+counter+pending), instantiated NUM_PLAYERS times via generate.
// TESTING (bench overrides COIN_PULSE_CYCLES=4, COIN_GAP_CYCLES=3, AUTOFIRE_PERIOD=2)
//  ps2_key toggles with {1,0,0x75} then {0,0,0x75} -> dir_out[3] high 2 clks after first event, low 2 after second.
//  ps2_key[10]=1 held through reset release, no change -> no key state changes, all outputs 0.
//  joy_in[16+4]=1 (P1 btn0, NUM_BUTTONS=2) -> btn_out[2]=1 after 1 clk; other bits 0.
//  coin key pressed 1 clk -> coin_out[0]=1 for exactly 4 clks, then 0; coin_busy falls after 3-clk gap.
//  5 coin edges during first pulse -> exactly 4 pulses total (1 + pending sat 3), each 4 high / 3 low.
//  Reset asserted mid-pulse -> coin_out=0 same cycle; after release no residual pulses.
//  AUTOFIRE_EN, autofire_en[0]=1, hold space 10 clks -> btn_out[0] pattern 1,1,0,0,1,1,...; 0 after release.

Source files
------------

// File: rtl/arcade_input_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arcade_input_pkg
//  Description : Shared definitions for the arcade input mapper. Joystick bit
//                indices, keyboard scancode table and the coin FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package arcade_input_pkg;

  // Joystick word bit positions (buttons start at JOY_BTN0)
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_BTN0  = 4;

  // Player 0 scancodes
  localparam logic [7:0] P0_UP    = 8'h75;
  localparam logic [7:0] P0_DOWN  = 8'h72;
  localparam logic [7:0] P0_LEFT  = 8'h6B;
  localparam logic [7:0] P0_RIGHT = 8'h74;
  localparam logic [7:0] P0_BTN0  = 8'h29;
  localparam logic [7:0] P0_BTN1  = 8'h14;
  localparam logic [7:0] P0_BTN2  = 8'h11;
  localparam logic [7:0] P0_BTN3  = 8'h12;
  localparam logic [7:0] P0_BTN4  = 8'h1A;
  localparam logic [7:0] P0_BTN5  = 8'h22;
  localparam logic [7:0] P0_START = 8'h16;
  localparam logic [7:0] P0_COIN  = 8'h2E;

  // Player 1 scancodes
  localparam logic [7:0] P1_UP    = 8'h2D;
  localparam logic [7:0] P1_DOWN  = 8'h2B;
  localparam logic [7:0] P1_LEFT  = 8'h23;
  localparam logic [7:0] P1_RIGHT = 8'h34;
  localparam logic [7:0] P1_BTN0  = 8'h1C;
  localparam logic [7:0] P1_BTN1  = 8'h1B;
  localparam logic [7:0] P1_BTN2  = 8'h15;
  localparam logic [7:0] P1_BTN3  = 8'h1D;
  localparam logic [7:0] P1_BTN4  = 8'h24;
  localparam logic [7:0] P1_BTN5  = 8'h2C;
  localparam logic [7:0] P1_START = 8'h1E;
  localparam logic [7:0] P1_COIN  = 8'h36;

  typedef enum logic [1:0] {
    COIN_IDLE  = 2'd0,
    COIN_PULSE = 2'd1,
    COIN_GAP   = 2'd2
  } coin_state_t;

  // Scancode of a direction key; dir uses the joystick bit index
  function automatic logic [7:0] key_dir_code(input int player, input int dir);
    logic [7:0] code;
    code = 8'h00;
    if (player == 0) begin
      case (dir)
        JOY_RIGHT: code = P0_RIGHT;
        JOY_LEFT:  code = P0_LEFT;
        JOY_DOWN:  code = P0_DOWN;
        default:   code = P0_UP;
      endcase
    end else begin
      case (dir)
        JOY_RIGHT: code = P1_RIGHT;
        JOY_LEFT:  code = P1_LEFT;
        JOY_DOWN:  code = P1_DOWN;
        default:   code = P1_UP;
      endcase
    end
    return code;
  endfunction

  // Scancode of fire button k (0..5)
  function automatic logic [7:0] key_btn_code(input int player, input int btn);
    logic [7:0] code;
    code = 8'h00;
    if (player == 0) begin
      case (btn)
        0:       code = P0_BTN0;
        1:       code = P0_BTN1;
        2:       code = P0_BTN2;
        3:       code = P0_BTN3;
        4:       code = P0_BTN4;
        default: code = P0_BTN5;
      endcase
    end else begin
      case (btn)
        0:       code = P1_BTN0;
        1:       code = P1_BTN1;
        2:       code = P1_BTN2;
        3:       code = P1_BTN3;
        4:       code = P1_BTN4;
        default: code = P1_BTN5;
      endcase
    end
    return code;
  endfunction

  function automatic logic [7:0] key_start_code(input int player);
    return (player == 0) ? P0_START : P1_START;
  endfunction

  function automatic logic [7:0] key_coin_code(input int player);
    return (player == 0) ? P0_COIN : P1_COIN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arcade_coin_pulser.sv
`default_nettype none
// ============================================================================
//  Module      : arcade_coin_pulser
//  Description : One coin channel. Turns single-cycle coin requests into
//                fixed-length high pulses separated by a minimum low gap, with
//                up to three requests queued while a pulse/gap is in progress.
//  Revision    : 1.0 - initial release
// ============================================================================
module arcade_coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int PULSE_CYCLES = 1800000,
  parameter int GAP_CYCLES   = 1800000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic req,
  output logic coin_out,
  output logic busy
);

  localparam int c_max_cycles = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
  localparam logic [c_cnt_w-1:0] c_pulse_last = c_cnt_w'(PULSE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last   = c_cnt_w'(GAP_CYCLES - 1);

  coin_state_t        r_state;
  coin_state_t        w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [1:0]         r_pend;
  logic [1:0]         w_pend_nxt;
  logic [2:0]         w_eff;
  logic [2:0]         w_eff_m1;
  logic [1:0]         w_pend_inc;
  logic [1:0]         w_pend_take;

  // State, counter and queue depth registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= COIN_IDLE;
      r_cnt   <= '0;
      r_pend  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Next state: w_eff is the queue depth including a same-cycle request, so a
  // request arriving exactly at the gap exit is never lost
  always_comb begin
    w_eff       = {1'b0, r_pend} + {2'b00, req};
    w_eff_m1    = w_eff - 3'd1;
    w_pend_inc  = (w_eff > 3'd3) ? 2'd3 : w_eff[1:0];
    w_pend_take = w_eff_m1[1:0];
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    case (r_state)
      COIN_IDLE: begin
        if (w_eff != 3'd0) begin
          w_state_nxt = COIN_PULSE;
          w_cnt_nxt   = '0;
          w_pend_nxt  = w_pend_take;
        end
      end
      COIN_PULSE: begin
        w_pend_nxt = w_pend_inc;
        if (r_cnt == c_pulse_last) begin
          w_state_nxt = COIN_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_w'(1);
        end
      end
      COIN_GAP: begin
        if (r_cnt == c_gap_last) begin
          w_cnt_nxt = '0;
          if (w_eff != 3'd0) begin
            w_state_nxt = COIN_PULSE;
            w_pend_nxt  = w_pend_take;
          end else begin
            w_state_nxt = COIN_IDLE;
            w_pend_nxt  = 2'd0;
          end
        end else begin
          w_cnt_nxt  = r_cnt + c_cnt_w'(1);
          w_pend_nxt = w_pend_inc;
        end
      end
      default: begin
        w_state_nxt = COIN_IDLE;
        w_cnt_nxt   = '0;
        w_pend_nxt  = 2'd0;
      end
    endcase
  end

  // Outputs decoded straight from registers so reset clears them immediately
  assign coin_out = (r_state == COIN_PULSE);
  assign busy     = (r_state != COIN_IDLE) || (r_pend != 2'd0);

endmodule
`default_nettype wire

// File: rtl/arcade_input_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : arcade_input_mapper
//  Description : Keyboard/joystick front end for arcade cores. Decodes ps2_key
//                toggle events into held key states, merges them with the
//                per-player joystick words and shapes coin requests into timed
//                pulses. Build option AUTOFIRE_EN adds per-button autofire and
//                the autofire_en port.
//  Revision    : 1.0 - initial release
// ============================================================================
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int NUM_PLAYERS       = 2,
  parameter int NUM_BUTTONS       = 2,
  parameter int COIN_PULSE_CYCLES = 1800000,
  parameter int COIN_GAP_CYCLES   = 1800000,
  parameter int AUTOFIRE_PERIOD   = 270000
) (
  input  logic                               clk_sys,
  input  logic                               reset,
  input  logic [10:0]                        ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]          joy_in,
  output logic [4*NUM_PLAYERS-1:0]           dir_out,
  output logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_out,
  output logic [NUM_PLAYERS-1:0]             start_out,
  output logic [NUM_PLAYERS-1:0]             coin_out,
  output logic                               coin_busy
`ifdef AUTOFIRE_EN
  ,
  input  logic [NUM_BUTTONS*NUM_PLAYERS-1:0] autofire_en
`endif
);

  // Only the first two players have keyboard mappings
  localparam int c_key_players = (NUM_PLAYERS < 2) ? NUM_PLAYERS : 2;
  localparam int c_nb          = NUM_BUTTONS;
  localparam int c_nbtn        = NUM_BUTTONS * NUM_PLAYERS;

  logic                       r_primed;
  logic                       r_toggle;
  logic                       w_event;
  logic [4*c_key_players-1:0] r_key_dir;
  logic [c_nb*c_key_players-1:0] r_key_btn;
  logic [c_key_players-1:0]   r_key_start;
  logic [c_key_players-1:0]   r_key_coin;

  logic [4*NUM_PLAYERS-1:0]   w_dir_lvl;
  logic [c_nbtn-1:0]          w_btn_lvl;
  logic [c_nbtn-1:0]          w_btn_next;
  logic [NUM_PLAYERS-1:0]     w_start_lvl;
  logic [NUM_PLAYERS-1:0]     w_coin_raw;
  logic [NUM_PLAYERS-1:0]     w_coin_req;
  logic [NUM_PLAYERS-1:0]     w_coin_busy;

  logic [4*NUM_PLAYERS-1:0]   r_dir;
  logic [c_nbtn-1:0]          r_btn;
  logic [NUM_PLAYERS-1:0]     r_start;
  logic [NUM_PLAYERS-1:0]     r_coin_prev;

  logic                       w_unused_ok;

  // ps2_key[10] toggles once per key event; first clock only primes the tracker
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_primed <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_primed <= 1'b1;
      r_toggle <= ps2_key[10];
    end
  end

  assign w_event = r_primed && (ps2_key[10] != r_toggle);

  // Held key states; the extended bit is deliberately ignored
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_key_dir   <= '0;
      r_key_btn   <= '0;
      r_key_start <= '0;
      r_key_coin  <= '0;
    end else if (w_event) begin
      for (int p = 0; p < c_key_players; p++) begin
        for (int d = 0; d < 4; d++) begin
          if (ps2_key[7:0] == key_dir_code(p, d)) r_key_dir[4*p+d] <= ps2_key[9];
        end
        for (int k = 0; k < c_nb; k++) begin
          if (ps2_key[7:0] == key_btn_code(p, k)) r_key_btn[c_nb*p+k] <= ps2_key[9];
        end
        if (ps2_key[7:0] == key_start_code(p)) r_key_start[p] <= ps2_key[9];
        if (ps2_key[7:0] == key_coin_code(p))  r_key_coin[p]  <= ps2_key[9];
      end
    end
  end

  // Merge key states with joystick bits into raw levels
  always_comb begin
    w_dir_lvl   = '0;
    w_btn_lvl   = '0;
    w_start_lvl = '0;
    w_coin_raw  = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_dir_lvl[4*p +: 4] = joy_in[16*p +: 4];
      for (int k = 0; k < c_nb; k++) begin
        w_btn_lvl[c_nb*p+k] = joy_in[16*p + JOY_BTN0 + k];
      end
      w_start_lvl[p] = joy_in[16*p + JOY_BTN0 + c_nb];
      w_coin_raw[p]  = joy_in[16*p + JOY_BTN0 + c_nb + 1];
    end
    for (int p = 0; p < c_key_players; p++) begin
      w_dir_lvl[4*p +: 4]       = w_dir_lvl[4*p +: 4] | r_key_dir[4*p +: 4];
      w_btn_lvl[c_nb*p +: c_nb] = w_btn_lvl[c_nb*p +: c_nb] | r_key_btn[c_nb*p +: c_nb];
      w_start_lvl[p]            = w_start_lvl[p] | r_key_start[p];
      w_coin_raw[p]             = w_coin_raw[p] | r_key_coin[p];
    end
  end

  assign w_coin_req = w_coin_raw & ~r_coin_prev;

`ifdef AUTOFIRE_EN
  localparam int c_af_w = $clog2(AUTOFIRE_PERIOD + 1);
  localparam logic [c_af_w-1:0] c_af_last = c_af_w'(AUTOFIRE_PERIOD - 1);

  logic [NUM_PLAYERS-1:0][c_af_w-1:0] r_af_cnt;
  logic [NUM_PLAYERS-1:0]             r_af_phase;
  logic [NUM_PLAYERS-1:0]             w_af_any;

  // A player's phase counter runs only while one of its autofire buttons is held
  always_comb begin
    w_af_any = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      w_af_any[p] = |(w_btn_lvl[c_nb*p +: c_nb] & autofire_en[c_nb*p +: c_nb]);
    end
  end

  // Phase starts high and flips every AUTOFIRE_PERIOD held cycles
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_af_cnt   <= '0;
      r_af_phase <= '1;
    end else begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (!w_af_any[p]) begin
          r_af_cnt[p]   <= '0;
          r_af_phase[p] <= 1'b1;
        end else if (r_af_cnt[p] == c_af_last) begin
          r_af_cnt[p]   <= '0;
          r_af_phase[p] <= ~r_af_phase[p];
        end else begin
          r_af_cnt[p] <= r_af_cnt[p] + c_af_w'(1);
        end
      end
    end
  end

  // Autofire-enabled buttons are gated by their player's phase
  always_comb begin
    w_btn_next = w_btn_lvl;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      for (int k = 0; k < c_nb; k++) begin
        if (autofire_en[c_nb*p+k] && !r_af_phase[p]) w_btn_next[c_nb*p+k] = 1'b0;
      end
    end
  end
`else
  // Plain merged button levels
  always_comb begin
    w_btn_next = w_btn_lvl;
  end
`endif

  // Registered output levels and coin edge history
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_dir       <= '0;
      r_btn       <= '0;
      r_start     <= '0;
      r_coin_prev <= '0;
    end else begin
      r_dir       <= w_dir_lvl;
      r_btn       <= w_btn_next;
      r_start     <= w_start_lvl;
      r_coin_prev <= w_coin_raw;
    end
  end

  genvar gp;
  generate
    for (gp = 0; gp < NUM_PLAYERS; gp++) begin : g_coin
      arcade_coin_pulser #(
        .PULSE_CYCLES(COIN_PULSE_CYCLES),
        .GAP_CYCLES  (COIN_GAP_CYCLES)
      ) u_pulser (
        .clk_sys (clk_sys),
        .reset   (reset),
        .req     (w_coin_req[gp]),
        .coin_out(coin_out[gp]),
        .busy    (w_coin_busy[gp])
      );
    end
  endgenerate

  assign dir_out   = r_dir;
  assign btn_out   = r_btn;
  assign start_out = r_start;
  assign coin_busy = |w_coin_busy;

  // Extended-key flag and spare joystick bits are intentionally unused
  assign w_unused_ok = &{1'b0, ps2_key[8], joy_in};

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_mapper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arcade_input_mapper
//  Description : Self-checking bench for arcade_input_mapper with short coin
//                and autofire timings and a scancode/countdown reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arcade_input_mapper;

  localparam int NP    = 2;
  localparam int NB    = 2;
  localparam int PULSE = 4;
  localparam int GAP   = 3;
  localparam int AFP   = 2;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic [10:0]   ps2_key = '0;
  logic [31:0]   joy_in  = '0;
  logic [7:0]    dir_out;
  logic [3:0]    btn_out;
  logic [1:0]    start_out;
  logic [1:0]    coin_out;
  logic          coin_busy;
`ifdef AUTOFIRE_EN
  logic [3:0]    autofire_en = '0;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit         m_keyst [256];
  bit         m_primed;
  bit         m_tog;
  logic [7:0] e_dir;
  logic [3:0] e_btn;
  logic [1:0] e_start;
  bit         m_prev [2];
  int         m_hi [2];
  int         m_lo [2];
  int         m_pend [2];
  int         m_afn [2];

  logic [7:0] kdir   [2][4] = '{'{8'h74, 8'h6B, 8'h72, 8'h75}, '{8'h34, 8'h23, 8'h2B, 8'h2D}};
  logic [7:0] kbtn   [2][6] = '{'{8'h29, 8'h14, 8'h11, 8'h12, 8'h1A, 8'h22},
                                '{8'h1C, 8'h1B, 8'h15, 8'h1D, 8'h24, 8'h2C}};
  logic [7:0] kstart [2]    = '{8'h16, 8'h1E};
  logic [7:0] kcoin  [2]    = '{8'h2E, 8'h36};
  logic [7:0] rcodes [26]   = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h11, 8'h12, 8'h1A,
                                8'h22, 8'h16, 8'h2E, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B,
                                8'h15, 8'h1D, 8'h24, 8'h2C, 8'h1E, 8'h36, 8'h55, 8'h00};

  arcade_input_mapper #(
    .NUM_PLAYERS      (NP),
    .NUM_BUTTONS      (NB),
    .COIN_PULSE_CYCLES(PULSE),
    .COIN_GAP_CYCLES  (GAP),
    .AUTOFIRE_PERIOD  (AFP)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_key    (ps2_key),
    .joy_in     (joy_in),
    .dir_out    (dir_out),
    .btn_out    (btn_out),
    .start_out  (start_out),
    .coin_out   (coin_out),
    .coin_busy  (coin_busy)
`ifdef AUTOFIRE_EN
    ,
    .autofire_en(autofire_en)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [1:0] m_coin();
    logic [1:0] v;
    for (int p = 0; p < NP; p++) v[p] = (m_hi[p] > 0);
    return v;
  endfunction

  function automatic logic m_busy();
    logic b;
    b = 1'b0;
    for (int p = 0; p < NP; p++) if (m_hi[p] > 0 || m_lo[p] > 0 || m_pend[p] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_keyst[i] = 1'b0;
    m_primed = 1'b0;
    m_tog    = 1'b0;
    e_dir    = '0;
    e_btn    = '0;
    e_start  = '0;
    for (int p = 0; p < NP; p++) begin
      m_prev[p] = 1'b0; m_hi[p] = 0; m_lo[p] = 0; m_pend[p] = 0; m_afn[p] = 0;
    end
  endtask

  // One clock of behaviour: outputs from pre-edge key states, then key update
  task automatic model_step();
    logic [7:0] nd;
    logic [3:0] nb;
    logic [1:0] ns;
    bit raw, req, lvl, any;
    int eff;
    for (int p = 0; p < NP; p++) begin
      for (int d = 0; d < 4; d++) nd[4*p+d] = m_keyst[kdir[p][d]] | joy_in[16*p+d];
      any = 1'b0;
      for (int k = 0; k < NB; k++) begin
        lvl = m_keyst[kbtn[p][k]] | joy_in[16*p+4+k];
`ifdef AUTOFIRE_EN
        if (autofire_en[NB*p+k]) begin
          if (lvl) any = 1'b1;
          lvl = lvl & (((m_afn[p] / AFP) % 2) == 0);
        end
`endif
        nb[NB*p+k] = lvl;
      end
      m_afn[p] = any ? m_afn[p] + 1 : 0;
      ns[p] = m_keyst[kstart[p]] | joy_in[16*p+4+NB];
      raw = m_keyst[kcoin[p]] | joy_in[16*p+5+NB];
      req = raw & ~m_prev[p];
      m_prev[p] = raw;
      if (m_hi[p] == 0 && m_lo[p] == 0) begin
        eff = m_pend[p] + int'(req);
        if (eff > 0) begin m_hi[p] = PULSE; m_pend[p] = eff - 1; end
      end else if (m_hi[p] > 0) begin
        m_hi[p]--;
        if (m_hi[p] == 0) m_lo[p] = GAP;
        m_pend[p] = (m_pend[p] + int'(req) > 3) ? 3 : m_pend[p] + int'(req);
      end else begin
        m_lo[p]--;
        eff = m_pend[p] + int'(req);
        if (m_lo[p] == 0) begin
          if (eff > 0) begin m_hi[p] = PULSE; m_pend[p] = (eff - 1 > 3) ? 3 : eff - 1; end
          else m_pend[p] = 0;
        end else begin
          m_pend[p] = (eff > 3) ? 3 : eff;
        end
      end
    end
    e_dir = nd; e_btn = nb; e_start = ns;
    if (!m_primed) begin
      m_primed = 1'b1;
      m_tog    = ps2_key[10];
    end else if (ps2_key[10] != m_tog) begin
      m_tog = ps2_key[10];
      m_keyst[ps2_key[7:0]] = ps2_key[9];
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic key_event(input logic pressed, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, 1'b0, code};
  endtask

  task automatic test_reset();
    ps2_key = 11'h400;
    joy_in  = '0;
    reset   = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    checks++;
    if ({dir_out, btn_out, start_out, coin_out, coin_busy} !== 17'h0) begin
      failures++;
      $display("FAIL reset_hold: got %h want 0", {dir_out, btn_out, start_out, coin_out, coin_busy});
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({dir_out, btn_out, start_out, coin_out, coin_busy} !== 17'h0) begin
        failures++;
        $display("FAIL reset_release cyc %0d: got %h want 0", i, {dir_out, btn_out, start_out, coin_out, coin_busy});
      end
    end
  endtask

  task automatic test_key_dir();
    logic exp_up [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    key_event(1'b1, 8'h75);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) key_event(1'b0, 8'h75);
      tick();
      checks++;
      if (dir_out[3] !== exp_up[i] || dir_out !== e_dir) begin
        failures++;
        $display("FAIL key_dir cyc %0d: dir_out=%h want up=%0b model=%h", i, dir_out, exp_up[i], e_dir);
      end
    end
  endtask

  task automatic test_joy_btn();
    joy_in = 32'h0010_0000;
    tick();
    checks++;
    if (btn_out !== 4'b0100 || dir_out !== 8'h0 || start_out !== 2'b0 || coin_out !== 2'b0) begin
      failures++;
      $display("FAIL joy_btn: btn=%b dir=%h start=%b coin=%b want btn=0100 rest 0", btn_out, dir_out, start_out, coin_out);
    end
    joy_in = '0;
    tick();
    checks++;
    if (btn_out !== 4'b0000) begin
      failures++;
      $display("FAIL joy_btn_release: btn=%b want 0000", btn_out);
    end
  endtask

  task automatic test_coin_single();
    int hi_n, busy_n;
    hi_n = 0; busy_n = 0;
    key_event(1'b1, 8'h2E);
    tick();
    key_event(1'b0, 8'h2E);
    for (int i = 0; i < 16; i++) begin
      tick();
      if (coin_out[0]) hi_n++;
      if (coin_busy) busy_n++;
      checks++;
      if (coin_out !== m_coin() || coin_busy !== m_busy()) begin
        failures++;
        $display("FAIL coin_single cyc %0d: coin=%b busy=%b want coin=%b busy=%b", i, coin_out, coin_busy, m_coin(), m_busy());
      end
    end
    checks++;
    if (hi_n != PULSE || busy_n != PULSE + GAP) begin
      failures++;
      $display("FAIL coin_single_len: high=%0d busy=%0d want high=%0d busy=%0d", hi_n, busy_n, PULSE, PULSE + GAP);
    end
  endtask

  // Toggle the player-0 joystick coin bit for n_tog cycles and count pulses
  task automatic coin_train(input string name, input int n_tog, input int n_wait, input int exp_pulses);
    int pulses;
    logic last;
    pulses = 0; last = 1'b0;
    for (int i = 0; i < n_tog + n_wait; i++) begin
      joy_in[7] = (i < n_tog) ? ((i % 2) == 0) : 1'b0;
      tick();
      if (coin_out[0] && !last) pulses++;
      last = coin_out[0];
      checks++;
      if (coin_out !== m_coin() || coin_busy !== m_busy()) begin
        failures++;
        $display("FAIL %s cyc %0d: coin=%b busy=%b want coin=%b busy=%b", name, i, coin_out, coin_busy, m_coin(), m_busy());
      end
    end
    checks++;
    if (pulses != exp_pulses || coin_busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_count: pulses=%0d busy=%b want pulses=%0d busy=0", name, pulses, coin_busy, exp_pulses);
    end
  endtask

  task automatic test_coin_queue();
    coin_train("coin_queue", 8, 30, 4);
  endtask

  task automatic test_coin_saturate();
    coin_train("coin_saturate", 20, 30, 6);
  endtask

  task automatic test_reset_mid_pulse();
    int hi_n;
    hi_n = 0;
    joy_in[7] = 1'b1;
    repeat (3) tick();
    checks++;
    if (coin_out[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_pulse_pre: coin=%b want 1", coin_out[0]);
    end
    #2;
    joy_in = '0;
    reset  = 1'b1;
    #1;
    checks++;
    if (coin_out !== 2'b00 || coin_busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_pulse_reset: coin=%b busy=%b want 00/0", coin_out, coin_busy);
    end
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (coin_out[0]) hi_n++;
    end
    checks++;
    if (hi_n != 0 || coin_busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_pulse_residual: high=%0d busy=%b want 0/0", hi_n, coin_busy);
    end
  endtask

`ifdef AUTOFIRE_EN
  task automatic test_autofire();
    logic pat [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    autofire_en = 4'b0001;
    key_event(1'b1, 8'h29);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (btn_out[0] !== pat[i] || btn_out !== e_btn) begin
        failures++;
        $display("FAIL autofire cyc %0d: btn=%b want bit0=%0b model=%b", i, btn_out, pat[i], e_btn);
      end
    end
    key_event(1'b0, 8'h29);
    repeat (2) tick();
    checks++;
    if (btn_out[0] !== 1'b0) begin
      failures++;
      $display("FAIL autofire_release: btn0=%b want 0", btn_out[0]);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3, 0) == 0) begin
        ps2_key = {~ps2_key[10], 1'($urandom), 1'($urandom), rcodes[$urandom_range(25, 0)]};
      end else if ($urandom_range(7, 0) == 0) begin
        ps2_key[9:0] = 10'($urandom);
      end
      if ($urandom_range(7, 0) == 0) joy_in = $urandom & $urandom & $urandom;
`ifdef AUTOFIRE_EN
      if ($urandom_range(31, 0) == 0) autofire_en = 4'($urandom);
`endif
      tick();
      checks++;
      if ({dir_out, btn_out, start_out, coin_out, coin_busy} !== {e_dir, e_btn, e_start, m_coin(), m_busy()}) begin
        failures++;
        $display("FAIL random cyc %0d: got dir=%h btn=%b start=%b coin=%b busy=%b want dir=%h btn=%b start=%b coin=%b busy=%b",
                 i, dir_out, btn_out, start_out, coin_out, coin_busy, e_dir, e_btn, e_start, m_coin(), m_busy());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_key_dir();
    test_joy_btn();
    test_coin_single();
    test_coin_queue();
    test_coin_saturate();
    test_reset_mid_pulse();
`ifdef AUTOFIRE_EN
    test_autofire();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
